// File: rtl/align_pipe.sv
// align_pipe: pipelined leading-zero normaliser with elastic valid/ready stages.
// Build option ALIGN_PIPE_CLAMP_EN limits every shift by the remaining exponent.
module align_pipe #(
    parameter int unsigned ORDER = 3,
    parameter int unsigned W     = 2 ** ORDER,
    parameter int unsigned EW    = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [EW-1:0]  in_exp,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [EW-1:0]  out_exp,
    output logic [ORDER:0] out_count,
    output logic           out_zero,
    output logic           out_denorm
);
    localparam int unsigned HW = 2 ** ORDER;
    localparam int unsigned L  = ORDER + 1;
    localparam int unsigned CW = ORDER + 1;

    logic [L-1:0]           stage_valid;
    logic [L-1:0]           stage_load;
    logic [L-1:0][W-1:0]    stage_data;
    logic [L-1:0][EW-1:0]   stage_exp;
    logic [L-1:0][CW-1:0]   stage_count;
    logic [L-1:0]           stage_zero;
    logic [L-1:0]           stage_flag;

    // Stage k loads when it or any stage after it is empty, or the consumer takes the head.
    always_comb begin
        stage_load = '0;
        for (int k = 0; k < L; k++) begin
            stage_load[k] = out_ready;
            for (int j = k; j < L; j++) begin
                if (!stage_valid[j]) begin
                    stage_load[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int unsigned S = (k == ORDER) ? 1 : (HW >> (k + 1));

        logic          src_valid;
        logic [W-1:0]  src_data;
        logic [EW-1:0] src_exp;
        logic [CW-1:0] src_count;
        logic          src_zero;
        logic          src_flag;

        logic          valid_q, valid_d;
        logic [W-1:0]  data_q, data_d;
        logic [EW-1:0] exp_q, exp_d;
        logic [CW-1:0] count_q, count_d;
        logic          zero_q, zero_d;
        logic          flag_q, flag_d;

        logic          top_zero;
        logic          exp_ok;
        logic          do_shift;

        if (k == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_exp   = in_exp;
            assign src_count = '0;
            assign src_zero  = (in_data[W-1 -: HW] == '0);
            assign src_flag  = 1'b0;
        end else begin : g_body
            assign src_valid = stage_valid[k-1];
            assign src_data  = stage_data[k-1];
            assign src_exp   = stage_exp[k-1];
            assign src_count = stage_count[k-1];
            assign src_zero  = stage_zero[k-1];
            assign src_flag  = stage_flag[k-1];
        end

        always_comb begin
            top_zero = (src_data[W-1 -: S] == '0);
            exp_ok   = (32'(src_exp) >= S);
`ifdef ALIGN_PIPE_CLAMP_EN
            do_shift = top_zero && exp_ok;
`else
            do_shift = top_zero;
`endif
            valid_d = stage_load[k] ? src_valid : valid_q;
            data_d  = data_q;
            exp_d   = exp_q;
            count_d = count_q;
            zero_d  = zero_q;
            flag_d  = flag_q;
            if (stage_load[k] && src_valid) begin
                data_d  = do_shift ? (src_data << S) : src_data;
                exp_d   = do_shift ? (src_exp - EW'(S)) : src_exp;
                count_d = do_shift ? (src_count + CW'(S)) : src_count;
                zero_d  = src_zero;
                // Clamped: the exponent blocked a wanted shift. Free: the subtraction borrowed.
                flag_d  = src_flag | (top_zero && !exp_ok);
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                exp_q   <= '0;
                count_q <= '0;
                zero_q  <= 1'b0;
                flag_q  <= 1'b0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                exp_q   <= exp_d;
                count_q <= count_d;
                zero_q  <= zero_d;
                flag_q  <= flag_d;
            end
        end

        assign stage_valid[k] = valid_q;
        assign stage_data[k]  = data_q;
        assign stage_exp[k]   = exp_q;
        assign stage_count[k] = count_q;
        assign stage_zero[k]  = zero_q;
        assign stage_flag[k]  = flag_q;
    end

    assign in_ready   = stage_load[0];
    assign out_valid  = stage_valid[L-1];
    assign out_data   = stage_data[L-1];
    assign out_exp    = stage_exp[L-1];
    assign out_count  = stage_count[L-1];
    assign out_zero   = stage_zero[L-1];
    assign out_denorm = stage_flag[L-1];

endmodule
